// File: rtl/interval_meter.sv
// Measures clock cycles between start and stop pulses, saturating at 2^W-1,
// and hands each captured interval to a consumer through a valid/ack register.
module interval_meter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         ack,
  output logic [W-1:0] value,
  output logic         valid,
  output logic         overflow,
  output logic         lost,
  output logic         busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           run_ovf_q, run_ovf_d;
  logic [W-1:0]   value_q, value_d;
  logic           valid_q, valid_d;
  logic           overflow_q, overflow_d;
  logic           lost_q, lost_d;
  logic           capture;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      run_ovf_q  <= 1'b0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      run_ovf_q  <= run_ovf_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      lost_q     <= lost_d;
    end
  end

  // A lap (start with stop) captures but stays in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (stop && !start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture    = (state_q == RUN) && stop;
    cnt_d      = cnt_q;
    run_ovf_d  = run_ovf_q;
    value_d    = value_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    lost_d     = lost_q;

    if (start) begin
      cnt_d     = CNT_ONE;
      run_ovf_d = 1'b0;
    end else if (state_q == RUN && !stop) begin
      if (cnt_q == CNT_MAX) run_ovf_d = 1'b1;
      else                  cnt_d = cnt_q + CNT_ONE;
    end

    // An ack arriving with a capture consumes the old result, so nothing is lost.
    if (capture) begin
      value_d    = cnt_q;
      overflow_d = run_ovf_q;
      valid_d    = 1'b1;
      lost_d     = valid_q && !ack;
    end else if (valid_q && ack) begin
      valid_d = 1'b0;
      lost_d  = 1'b0;
    end
  end

  always_comb begin
    value    = value_q;
    valid    = valid_q;
    overflow = overflow_q;
    lost     = lost_q;
    busy     = (state_q == RUN);
  end

endmodule

// File: tb/tb_interval_meter.sv
// Scoreboard bench for interval_meter (W=8): expected captures are queued when
// the stop pulse is driven and compared after the edge that samples it.
module tb_interval_meter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       ack   = 1'b0;
  logic [7:0] value;
  logic       valid, overflow, lost, busy;

  typedef struct {
    logic [7:0] value;
    logic       ovf;
    logic       lost;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  interval_meter #(.W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .ack(ack),
    .value(value), .valid(valid), .overflow(overflow), .lost(lost), .busy(busy)
  );

  always #5 clock = ~clock;

  // Drive one cycle of inputs, let the edge sample them, then observe #1 later.
  task automatic tick(input logic s, input logic p, input logic a);
    start = s; stop = p; ack = a;
    @(posedge clock); #1;
    start = 1'b0; stop = 1'b0; ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [7:0] v, input logic o, input logic l);
    exp_t x;
    x.value = v; x.ovf = o; x.lost = l;
    exp_q.push_back(x);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    n_checks++;
    if ({value, valid, overflow, lost, busy} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: got value=%0d v=%b o=%b l=%b b=%b, want all 0",
               value, valid, overflow, lost, busy);
    end
  endtask

  task automatic test_basic;
    tick(1'b1, 1'b0, 1'b0);
    idle(4);
    n_checks++;
    if ({valid, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL basic_running: got valid=%b busy=%b, want 0 1", valid, busy);
    end
    push(8'd5, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if ({valid, busy, value, overflow, lost} !== {1'b1, 1'b0, e.value, e.ovf, e.lost}) begin
      n_fail++;
      $display("FAIL basic_capture: got v=%b b=%b value=%0d o=%b l=%b, want 1 0 %0d %b %b",
               valid, busy, value, overflow, lost, e.value, e.ovf, e.lost);
    end
    idle(3);
    tick(1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({valid, value} !== {1'b0, 8'd5}) begin
      n_fail++;
      $display("FAIL basic_ack: got valid=%b value=%0d, want 0 5", valid, value);
    end
    tick(1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({valid, lost, value} !== {1'b0, 1'b0, 8'd5}) begin
      n_fail++;
      $display("FAIL ack_when_empty: got valid=%b lost=%b value=%0d, want 0 0 5", valid, lost, value);
    end
  endtask

  task automatic test_restart;
    int early_valid = 0;
    tick(1'b1, 1'b0, 1'b0);
    idle(2);
    if (valid) early_valid++;
    tick(1'b1, 1'b0, 1'b0);
    if (valid) early_valid++;
    idle(3);
    if (valid) early_valid++;
    n_checks++;
    if (early_valid !== 0) begin
      n_fail++;
      $display("FAIL restart_no_capture: got %0d early valid samples, want 0", early_valid);
    end
    push(8'd4, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if ({valid, value, overflow, lost} !== {1'b1, e.value, e.ovf, e.lost}) begin
      n_fail++;
      $display("FAIL restart_capture: got v=%b value=%0d o=%b l=%b, want 1 %0d %b %b",
               valid, value, overflow, lost, e.value, e.ovf, e.lost);
    end
    tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_lap(input logic ack_between);
    tick(1'b1, 1'b0, 1'b0);
    idle(5);
    push(8'd6, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if ({valid, busy, value, overflow, lost} !== {1'b1, 1'b1, e.value, e.ovf, e.lost}) begin
      n_fail++;
      $display("FAIL lap_first: got v=%b b=%b value=%0d o=%b l=%b, want 1 1 %0d %b %b",
               valid, busy, value, overflow, lost, e.value, e.ovf, e.lost);
    end
    idle(1);
    tick(1'b0, 1'b0, ack_between);
    push(8'd3, 1'b0, !ack_between);
    tick(1'b0, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if ({valid, busy, value, overflow, lost} !== {1'b1, 1'b0, e.value, e.ovf, e.lost}) begin
      n_fail++;
      $display("FAIL lap_second(ack=%b): got v=%b b=%b value=%0d o=%b l=%b, want 1 0 %0d %b %b",
               ack_between, valid, busy, value, overflow, lost, e.value, e.ovf, e.lost);
    end
    tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_overflow;
    tick(1'b1, 1'b0, 1'b0);
    idle(254);
    push(8'd255, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if ({valid, value, overflow} !== {1'b1, e.value, e.ovf}) begin
      n_fail++;
      $display("FAIL ovf_exact_255: got v=%b value=%0d o=%b, want 1 %0d %b",
               valid, value, overflow, e.value, e.ovf);
    end
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    idle(299);
    push(8'd255, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if ({valid, value, overflow} !== {1'b1, e.value, e.ovf}) begin
      n_fail++;
      $display("FAIL ovf_300: got v=%b value=%0d o=%b, want 1 %0d %b",
               valid, value, overflow, e.value, e.ovf);
    end
    tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_corners;
    tick(1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({valid, busy, value, overflow} !== {1'b0, 1'b0, 8'd255, 1'b1}) begin
      n_fail++;
      $display("FAIL stop_in_idle: got v=%b b=%b value=%0d o=%b, want 0 0 255 1",
               valid, busy, value, overflow);
    end
    tick(1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({valid, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL start_stop_idle: got valid=%b busy=%b, want 0 1", valid, busy);
    end
    idle(2);
    push(8'd3, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if ({valid, value, overflow, lost} !== {1'b1, e.value, e.ovf, e.lost}) begin
      n_fail++;
      $display("FAIL corner_capture: got v=%b value=%0d o=%b l=%b, want 1 %0d %b %b",
               valid, value, overflow, lost, e.value, e.ovf, e.lost);
    end
    tick(1'b1, 1'b0, 1'b0);
    idle(1);
    push(8'd2, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    e = exp_q.pop_front();
    n_checks++;
    if ({valid, value, overflow, lost} !== {1'b1, e.value, e.ovf, e.lost}) begin
      n_fail++;
      $display("FAIL capture_with_ack: got v=%b value=%0d o=%b l=%b, want 1 %0d %b %b",
               valid, value, overflow, lost, e.value, e.ovf, e.lost);
    end
  endtask

  task automatic test_reset_mid;
    tick(1'b1, 1'b0, 1'b0);
    idle(3);
    push(8'd4, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if ({valid, value, overflow, lost} !== {1'b1, e.value, e.ovf, e.lost}) begin
      n_fail++;
      $display("FAIL pre_reset_capture: got v=%b value=%0d o=%b l=%b, want 1 %0d %b %b",
               valid, value, overflow, lost, e.value, e.ovf, e.lost);
    end
    tick(1'b1, 1'b0, 1'b0);
    idle(2);
    reset = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    n_checks++;
    if ({value, valid, overflow, lost, busy} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid_run: got value=%0d v=%b o=%b l=%b b=%b, want all 0",
               value, valid, overflow, lost, busy);
    end
    tick(1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({value, valid, busy} !== 10'h000) begin
      n_fail++;
      $display("FAIL stop_after_reset: got value=%0d v=%b b=%b, want 0 0 0", value, valid, busy);
    end
  endtask

  initial begin
    #1;
    test_reset();
    idle(4);
    test_basic();
    test_restart();
    test_lap(1'b0);
    test_lap(1'b1);
    test_overflow();
    test_corners();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
